// File: rtl/cpu_pkg.sv
// Shared opcode encodings, sequencer state codes and instruction classes for the CPU control path.
package cpu_pkg;

  // Upper three opcode bits select the two-byte instructions (bit 0 is ignored).
  localparam logic [2:0] OpHiLdm = 3'b000;
  localparam logic [2:0] OpHiStm = 3'b001;
  localparam logic [2:0] OpHiJmp = 3'b010;
  localparam logic [2:0] OpHiJcc = 3'b011;

  localparam logic [3:0] OpAdd = 4'b1000;
  localparam logic [3:0] OpAdc = 4'b1001;
  localparam logic [3:0] OpSub = 4'b1010;
  localparam logic [3:0] OpAnd = 4'b1011;
  localparam logic [3:0] OpMov = 4'b1100;
  localparam logic [3:0] OpMvi = 4'b1101;
  localparam logic [3:0] OpLdf = 4'b1110;
  localparam logic [3:0] OpNop = 4'b1111;

  localparam logic [3:0] StF1   = 4'd0;
  localparam logic [3:0] StF1w  = 4'd1;
  localparam logic [3:0] StDec  = 4'd2;
  localparam logic [3:0] StF2   = 4'd3;
  localparam logic [3:0] StExa  = 4'd4;
  localparam logic [3:0] StWba  = 4'd5;
  localparam logic [3:0] StMrd  = 4'd6;
  localparam logic [3:0] StMwr  = 4'd7;
  localparam logic [3:0] StBr   = 4'd8;
  localparam logic [3:0] StHalt = 4'd9;

  typedef enum logic [3:0] {
    ClsLdm,
    ClsStm,
    ClsJmp,
    ClsJcc,
    ClsAlu,
    ClsMov,
    ClsMvi,
    ClsLdf,
    ClsNop
  } instr_class_e;

  // Instructions that need the second instruction byte fetched into TR.
  function automatic logic needs_fetch2(instr_class_e cls);
    return (cls == ClsLdm) || (cls == ClsStm) || (cls == ClsJmp) || (cls == ClsJcc) ||
           (cls == ClsMvi);
  endfunction

endpackage

// File: rtl/op_decoder.sv
// Combinational opcode classifier: IR[7:4] to instruction class.
module op_decoder
  import cpu_pkg::*;
(
  input  logic [3:0]   opcode,
  output instr_class_e instr_class
);

  always_comb begin
    instr_class = ClsNop;
    if (!opcode[3]) begin
      case (opcode[3:1])
        OpHiLdm: instr_class = ClsLdm;
        OpHiStm: instr_class = ClsStm;
        OpHiJmp: instr_class = ClsJmp;
        OpHiJcc: instr_class = ClsJcc;
        default: instr_class = ClsNop;
      endcase
    end else begin
      case (opcode)
        OpAdd, OpAdc, OpSub, OpAnd: instr_class = ClsAlu;
        OpMov:                      instr_class = ClsMov;
        OpMvi:                      instr_class = ClsMvi;
        OpLdf:                      instr_class = ClsLdf;
        default:                    instr_class = ClsNop;
      endcase
    end
  end

endmodule

// File: rtl/seq_controller.sv
// Multi-cycle instruction sequencer: fetch/decode/execute FSM with debug halt and single-step.
module seq_controller
  import cpu_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] instruction,
  input  logic [1:0] dst_fld,
  input  logic       jmp_taken,
  input  logic       mem_ready,
  input  logic       halt_req,
  input  logic       step,
  output logic       ld_PC,
  output logic       ld_IR,
  output logic       ld_DI,
  output logic       ld_TR,
  output logic       ld_ALU,
  output logic       ld_CZN,
  output logic       MEM_read,
  output logic       MEM_write,
  output logic       sel_MEM_src_PC,
  output logic       sel_MEM_src_TR,
  output logic       write_reg_en,
  output logic       sel_IR_3_2,
  output logic       sel_DI_4_3,
  output logic       sel_RF_write_src_TR_12_5,
  output logic       sel_RF_write_src_reg1,
  output logic       sel_RF_write_src_ALU,
  output logic       sel_ALU_src_reg1,
  output logic       sel_ALU_src_TR,
  output logic       sel_CZN_src_ALU,
  output logic       sel_CZN_src_RF,
  output logic       sel_PC_src_JUMP,
  output logic       halted
);

  logic [3:0]   state_q, state_d;
  logic [3:0]   done_state;
  logic         br_load;
  instr_class_e cls;

  // The destination field steers the datapath directly; the sequencer never inspects it.
  logic unused_dst;
  assign unused_dst = ^dst_fld;

  op_decoder u_op_decoder (
    .opcode      (instruction),
    .instr_class (cls)
  );

  // halt_req is only looked at when an instruction retires, so nothing is cut short.
  assign done_state = halt_req ? StHalt : StF1;
  assign br_load    = (cls == ClsJmp) || ((cls == ClsJcc) && jmp_taken);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StF1;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StF1, StF1w: state_d = mem_ready ? StDec : StF1w;
      StDec: begin
        if (needs_fetch2(cls))   state_d = StF2;
        else if (cls == ClsAlu)  state_d = StExa;
        else                     state_d = done_state;
      end
      StF2: begin
        if (mem_ready) begin
          case (cls)
            ClsMvi:         state_d = StWba;
            ClsLdm:         state_d = StMrd;
            ClsStm:         state_d = StMwr;
            ClsJmp, ClsJcc: state_d = StBr;
            default:        state_d = done_state;
          endcase
        end
      end
      StExa:        state_d = StWba;
      StWba, StBr:  state_d = done_state;
      StMrd, StMwr: state_d = mem_ready ? done_state : state_q;
      StHalt:       state_d = step ? StF1 : StHalt;
      default:      state_d = StF1;
    endcase
  end

  always_comb begin
    ld_PC                    = 1'b0;
    ld_IR                    = 1'b0;
    ld_DI                    = 1'b0;
    ld_TR                    = 1'b0;
    ld_ALU                   = 1'b0;
    ld_CZN                   = 1'b0;
    MEM_read                 = 1'b0;
    MEM_write                = 1'b0;
    sel_MEM_src_PC           = 1'b0;
    sel_MEM_src_TR           = 1'b0;
    write_reg_en             = 1'b0;
    sel_IR_3_2               = 1'b0;
    sel_DI_4_3               = 1'b0;
    sel_RF_write_src_TR_12_5 = 1'b0;
    sel_RF_write_src_reg1    = 1'b0;
    sel_RF_write_src_ALU     = 1'b0;
    sel_ALU_src_reg1         = 1'b0;
    sel_ALU_src_TR           = 1'b0;
    sel_CZN_src_ALU          = 1'b0;
    sel_CZN_src_RF           = 1'b0;
    sel_PC_src_JUMP          = 1'b0;
    halted                   = 1'b0;
    // Reset masks every strobe combinationally so an in-flight access is dropped at once.
    if (rst) begin
      case (state_q)
        StF1, StF1w: begin
          MEM_read       = 1'b1;
          sel_MEM_src_PC = 1'b1;
          ld_IR          = mem_ready;
          ld_PC          = mem_ready;
        end
        StDec: begin
          ld_DI = 1'b1;
          if (cls == ClsMov) begin
            write_reg_en          = 1'b1;
            sel_IR_3_2            = 1'b1;
            sel_RF_write_src_reg1 = 1'b1;
          end
          if (cls == ClsLdf) begin
            ld_CZN         = 1'b1;
            sel_CZN_src_RF = 1'b1;
          end
        end
        StF2: begin
          MEM_read       = 1'b1;
          sel_MEM_src_PC = 1'b1;
          ld_TR          = mem_ready;
          ld_PC          = mem_ready;
        end
        StExa: begin
          sel_ALU_src_reg1 = 1'b1;
          ld_ALU           = 1'b1;
          ld_CZN           = 1'b1;
          sel_CZN_src_ALU  = 1'b1;
        end
        StWba: begin
          write_reg_en             = 1'b1;
          sel_IR_3_2               = 1'b1;
          sel_RF_write_src_TR_12_5 = (cls == ClsMvi);
          sel_RF_write_src_ALU     = (cls != ClsMvi);
        end
        StMrd: begin
          MEM_read       = 1'b1;
          sel_MEM_src_TR = 1'b1;
          write_reg_en   = mem_ready;
          sel_DI_4_3     = mem_ready;
        end
        StMwr: begin
          MEM_write      = 1'b1;
          sel_MEM_src_TR = 1'b1;
          sel_DI_4_3     = 1'b1;
        end
        StBr: begin
          sel_PC_src_JUMP = br_load;
          ld_PC           = br_load;
        end
        StHalt:  halted = 1'b1;
        default: ;
      endcase
    end
  end

endmodule
